// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NUM_RD async reads, NUM_WR sync writes, x0 hardwired to zero,
// post-reset clear sequencer and write-conflict flag. Optional macro RF_WR_BYPASS_EN adds write-through reads.
module reg_file_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 3,
    parameter int unsigned NUM_WR     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic                         init_busy,
    output logic                         wr_conflict
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    init_busy_q, init_busy_d;
    logic                    wr_conflict_q, wr_conflict_d;
    logic [DATA_WIDTH-1:0]   rf_q [DEPTH];
    logic [DATA_WIDTH-1:0]   rf_d [DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_val;

    // Next state: reset beats everything, CLEAR zeroes one entry per cycle, READY applies writes.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        init_busy_d   = init_busy_q;
        wr_conflict_d = 1'b0;
        rf_d          = rf_q;
        if (rst) begin
            state_d     = CLEAR;
            clr_cnt_d   = ADDR_WIDTH'(1);
            init_busy_d = 1'b1;
        end else if (state_q == CLEAR) begin
            rf_d[clr_cnt_q] = '0;
            clr_cnt_d       = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d     = READY;
                init_busy_d = 1'b0;
            end
        end else begin
            // Ascending order lets the highest-index port win a same-address collision.
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                if (we[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    rf_d[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            for (int unsigned i = 0; i < NUM_WR; i++) begin
                for (int unsigned k = i + 1; k < NUM_WR; k++) begin
                    if (we[i] && we[k]
                        && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == waddr[k*ADDR_WIDTH +: ADDR_WIDTH])
                        && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                        wr_conflict_d = 1'b1;
                    end
                end
            end
        end
        rf_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        clr_cnt_q     <= clr_cnt_d;
        init_busy_q   <= init_busy_d;
        wr_conflict_q <= wr_conflict_d;
        rf_q          <= rf_d;
    end

    // Combinational read lanes; everything reads zero until the clear completes.
    always_comb begin
        rdata   = '0;
        rd_addr = '0;
        rd_val  = '0;
        for (int unsigned j = 0; j < NUM_RD; j++) begin
            rd_addr = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
            rd_val  = '0;
            if ((state_q == READY) && (rd_addr != '0)) begin
                rd_val = rf_q[rd_addr];
`ifdef RF_WR_BYPASS_EN
                for (int unsigned i = 0; i < NUM_WR; i++) begin
                    if (we[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr)) begin
                        rd_val = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
`else
`endif
            end
            rdata[j*DATA_WIDTH +: DATA_WIDTH] = rd_val;
        end
    end

    assign init_busy   = init_busy_q;
    assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized self-checking bench for reg_file_mp against an array-based architectural model.
module tb_reg_file_mp;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NR    = 3;
    localparam int unsigned NW    = 2;
    localparam int unsigned DEPTH = 2 ** AW;

    logic             clk = 1'b0;
    logic             rst;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic             init_busy;
    logic             wr_conflict;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model: register contents, remaining clear cycles, expected conflict pulse.
    logic [DW-1:0] ref_rf [DEPTH];
    int            clear_left = DEPTH - 1;
    logic          m_conflict = 1'b0;

    reg_file_mp dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .init_busy(init_busy), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] wa(int i);
        return waddr[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] exp_rd(int j);
        logic [AW-1:0] a;
        logic [DW-1:0] v;
        a = raddr[j*AW +: AW];
        if (clear_left != 0 || a == 0) return '0;
        v = ref_rf[a];
`ifdef RF_WR_BYPASS_EN
        for (int i = 0; i < NW; i++)
            if (we[i] && wa(i) == a) v = wdata[i*DW +: DW];
`endif
        return v;
    endfunction

    task automatic model_update();
        m_conflict = 1'b0;
        if (rst) begin
            clear_left = DEPTH - 1;
        end else if (clear_left != 0) begin
            clear_left--;
            if (clear_left == 0)
                for (int a = 0; a < DEPTH; a++) ref_rf[a] = '0;
        end else begin
            for (int i = 0; i < NW; i++)
                for (int k = i + 1; k < NW; k++)
                    if (we[i] && we[k] && wa(i) == wa(k) && wa(i) != 0) m_conflict = 1'b1;
            for (int i = 0; i < NW; i++)
                if (we[i] && wa(i) != 0) ref_rf[wa(i)] = wdata[i*DW +: DW];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_wr(int p, logic en, logic [AW-1:0] a, logic [DW-1:0] d);
        we[p]             = en;
        waddr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic set_rd(int j, logic [AW-1:0] a);
        raddr[j*AW +: AW] = a;
    endtask

    task automatic test_reset();
        int busy_cycles;
        rst = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
        step(); step();
        n_checks++;
        if (init_busy !== 1'b1 || wr_conflict !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b conflict=%b, required busy=1 conflict=0", init_busy, wr_conflict);
        end
        rst = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 40 && init_busy === 1'b1; c++) begin
            busy_cycles++;
            set_wr(0, 1'b1, AW'(5), DW'($urandom));
            set_wr(1, 1'b1, AW'(5), DW'($urandom));
            for (int j = 0; j < NR; j++) set_rd(j, AW'($urandom_range(1, DEPTH - 1)));
            #1;
            n_checks++;
            if (rdata !== '0 || wr_conflict !== 1'b0) begin
                n_errors++;
                $display("FAIL clear_quiet: rdata=%h conflict=%b, required 0 and 0", rdata, wr_conflict);
            end
            step();
        end
        n_checks++;
        if (busy_cycles != DEPTH - 1 || init_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_length: busy for %0d cycles (busy now %b), required %0d then 0",
                     busy_cycles, init_busy, DEPTH - 1);
        end
        we = '0;
        for (int a = 0; a < DEPTH; a++) begin
            for (int j = 0; j < NR; j++) set_rd(j, AW'(a));
            #1;
            n_checks++;
            if (rdata !== '0) begin
                n_errors++;
                $display("FAIL cleared_reg: x%0d rdata=%h, required 0", a, rdata);
            end
        end
        step();
        n_checks++;
        if (wr_conflict !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_no_conflict: conflict=%b, required 0", wr_conflict);
        end
    endtask

    task automatic test_basic();
        we = '0;
        set_wr(0, 1'b1, AW'(7), 32'hDEADBEEF);
        step();
        we = '0;
        for (int j = 0; j < NR; j++) set_rd(j, AW'(7));
        #1;
        for (int j = 0; j < NR; j++) begin
            n_checks++;
            if (rdata[j*DW +: DW] !== 32'hDEADBEEF) begin
                n_errors++;
                $display("FAIL basic_x7: lane %0d rdata=%h, required deadbeef", j, rdata[j*DW +: DW]);
            end
        end
        set_wr(0, 1'b1, AW'(0), 32'h1234);
        step();
        we = '0;
        for (int j = 0; j < NR; j++) set_rd(j, AW'(0));
        #1;
        n_checks++;
        if (rdata !== '0) begin
            n_errors++;
            $display("FAIL basic_x0: rdata=%h, required 0", rdata);
        end
    endtask

    task automatic test_conflict();
        set_wr(0, 1'b1, AW'(9), 32'hAAAA0000);
        set_wr(1, 1'b1, AW'(9), 32'h5555FFFF);
        step();
        we = '0;
        set_rd(0, AW'(9));
        #1;
        n_checks++;
        if (wr_conflict !== 1'b1 || rdata[0 +: DW] !== 32'h5555FFFF) begin
            n_errors++;
            $display("FAIL conflict_x9: conflict=%b rdata0=%h, required 1 and 5555ffff", wr_conflict, rdata[0 +: DW]);
        end
        step();
        n_checks++;
        if (wr_conflict !== 1'b0) begin
            n_errors++;
            $display("FAIL conflict_pulse: conflict=%b one cycle later, required 0", wr_conflict);
        end
        set_wr(0, 1'b1, AW'(0), 32'h1);
        set_wr(1, 1'b1, AW'(0), 32'h2);
        step();
        we = '0;
        n_checks++;
        if (wr_conflict !== 1'b0) begin
            n_errors++;
            $display("FAIL conflict_x0: conflict=%b, required 0", wr_conflict);
        end
    endtask

    task automatic test_dual_write();
        set_wr(0, 1'b1, AW'(3), 32'h11);
        set_wr(1, 1'b1, AW'(4), 32'h22);
        step();
        we = '0;
        set_rd(0, AW'(3));
        set_rd(2, AW'(4));
        #1;
        n_checks++;
        if (rdata[0 +: DW] !== 32'h11 || rdata[2*DW +: DW] !== 32'h22 || wr_conflict !== 1'b0) begin
            n_errors++;
            $display("FAIL dual_write: x3=%h x4=%h conflict=%b, required 11 22 0",
                     rdata[0 +: DW], rdata[2*DW +: DW], wr_conflict);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old_val;
        logic [DW-1:0] want;
        old_val = ref_rf[12];
        we = '0;
        set_wr(1, 1'b1, AW'(12), 32'hCAFE0001);
        set_rd(0, AW'(12));
`ifdef RF_WR_BYPASS_EN
        want = 32'hCAFE0001;
`else
        want = old_val;
`endif
        #1;
        n_checks++;
        if (rdata[0 +: DW] !== want) begin
            n_errors++;
            $display("FAIL bypass_same_cycle: rdata0=%h, required %h", rdata[0 +: DW], want);
        end
        step();
        we = '0;
        #1;
        n_checks++;
        if (rdata[0 +: DW] !== 32'hCAFE0001) begin
            n_errors++;
            $display("FAIL bypass_next_cycle: rdata0=%h, required cafe0001", rdata[0 +: DW]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NW; i++)
                set_wr(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            for (int j = 0; j < NR; j++) set_rd(j, AW'($urandom_range(0, 7)));
            #1;
            for (int j = 0; j < NR; j++) begin
                n_checks++;
                if (rdata[j*DW +: DW] !== exp_rd(j)) begin
                    n_errors++;
                    $display("FAIL random_read: cycle %0d lane %0d addr %0d rdata=%h, required %h",
                             c, j, raddr[j*AW +: AW], rdata[j*DW +: DW], exp_rd(j));
                end
            end
            step();
            n_checks++;
            if (wr_conflict !== m_conflict) begin
                n_errors++;
                $display("FAIL random_conflict: cycle %0d conflict=%b, required %b", c, wr_conflict, m_conflict);
            end
        end
        we = '0;
    endtask

    task automatic test_reset_mid_clear();
        int busy_cycles;
        we = '0;
        set_wr(0, 1'b1, AW'(20), 32'h77);
        step();
        we = '0;
        set_rd(1, AW'(20));
        #1;
        n_checks++;
        if (rdata[DW +: DW] !== 32'h77) begin
            n_errors++;
            $display("FAIL mid_prewrite: x20=%h, required 77", rdata[DW +: DW]);
        end
        rst = 1'b1; step(); rst = 1'b0;
        for (int c = 0; c < 10; c++) step();
        rst = 1'b1; step(); rst = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 40 && init_busy === 1'b1; c++) begin
            busy_cycles++;
            step();
        end
        n_checks++;
        if (busy_cycles != DEPTH - 1) begin
            n_errors++;
            $display("FAIL mid_clear_length: busy for %0d cycles, required %0d", busy_cycles, DEPTH - 1);
        end
        #1;
        n_checks++;
        if (rdata[DW +: DW] !== 32'h0) begin
            n_errors++;
            $display("FAIL mid_clear_x20: x20=%h, required 0", rdata[DW +: DW]);
        end
    endtask

    initial begin
        rst = 1'b1; we = '0; waddr = '0; wdata = '0; raddr = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_conflict();
        test_dual_write();
        test_bypass();
        test_random();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
